rca_chunk_seq_adder: RTL and testbench
======================================

Name: rca_chunk_seq_adder

Overview:
- Sequential front-end that adds two WIDTH-bit operands by feeding CHUNK-bit slices into one `rca_8bit` ripple-carry adder, one slice per cycle.
- The carry out of each slice is registered and fed back as the carry into the next slice.
- Trades latency for area, so wide adds reuse a single 8-bit ripple stage.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand/result width. Must be an integer multiple of CHUNK.
- CHUNK, 8, slice width per cycle. Fixed to match the 8-bit adder instance.
- NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand request
- in_ready  output  1  block can accept operands
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry in to bit 0
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  A+B+cin, low WIDTH bits
- out_cout  output  1  carry out of bit WIDTH-1

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - state=IDLE; out_valid=0; out_sum=0; out_cout=0; chunk counter=0; carry reg=0.
  - in_ready=0 while rst=1.
- FSM IDLE / RUN / DONE:
  - in_ready = (state==IDLE) && !rst.
  - out_valid = (state==DONE).
- IDLE: on in_valid && in_ready:
  - capture in_a and in_b into shift regs a_sh, b_sh; carry reg <= in_cin; count <= 0; go to RUN.
  - in_valid without in_ready is ignored, and the inputs are not sampled.
- RUN, each cycle:
  - Adder inputs: a_sh[CHUNK-1:0], b_sh[CHUNK-1:0], carry reg.
  - sum_sh <= {chunk_sum, sum_sh[WIDTH-1:CHUNK]}, filling MSB-first by right shift.
  - carry reg <= chunk carry_out.
  - a_sh and b_sh shift right by CHUNK.
  - count++.
  - When count==NCHUNK-1, the same edge loads out_sum with the final sum_sh value and out_cout with the chunk carry_out, and the state goes to DONE.
- DONE:
  - out_valid=1; out_sum and out_cout are held stable.
  - On out_ready=1, go to IDLE; out_sum and out_cout retain their value after the handoff.
- Latency and throughput:
  - out_valid rises NCHUNK clock edges after the accept edge (4 for defaults).
  - Maximum throughput is one result per NCHUNK+2 cycles. No accept occurs in the same cycle as the DONE handoff.
- Arithmetic: {out_cout, out_sum} == in_a + in_b + in_cin, evaluated at full WIDTH+1 bits with no overflow flagging.
- Boundary cases:
  - NCHUNK=1: RUN lasts one cycle. The counter is at least 1 bit wide.
  - Full carry propagation across all slices must be exact (e.g. all-ones + cin).
  - out_ready held low stalls in DONE indefinitely; in_ready stays 0 for the whole stall.
  - rst asserted in any state (including mid-RUN or DONE) aborts the operation. The next cycle is IDLE with the reset values above, and the partial result is discarded.
  - X on in_a/in_b while not accepting must not propagate to outputs.

Decomposition:
- rca_pkg holds:
  - localparam CHUNK_W=8;
  - the state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - a helper constant function for the counter width (clog2, minimum 1).
- Sub-module: one instance of the existing `rca_8bit` as the slice datapath.
- All sequencing (FSM, shift regs, carry reg, output regs) lives in rca_chunk_seq_adder.
- Elaboration check: WIDTH % CHUNK == 0.

Test Plan:
- Reset: hold rst for 2 cycles, then release → during rst in_ready=0, out_valid=0, out_sum=0x0000_0000, out_cout=0; first cycle after release in_ready=1.
- Carry into slice 1: A=0x0000_00FF, B=0x0000_0001, cin=0 → out_sum=0x0000_0100, out_cout=0; out_valid exactly 4 edges after the accept edge.
- Full ripple: A=0xFFFF_FFFF, B=0x0000_0000, cin=1 → out_sum=0x0000_0000, out_cout=1. Also A=0x8000_0000, B=0x8000_0000, cin=0 → out_sum=0, out_cout=1.
- Backpressure: result 0x2345_6789 with out_ready=0 for 5 cycles, while in_valid=1 with new operands → out_valid and out_sum stable, in_ready=0, new operands not taken. After out_ready=1, the next accept occurs the following cycle.
- Reset mid-RUN: assert rst after 2 RUN cycles → next cycle IDLE, out_valid=0, out_sum=0. Then A=0x1234_5678, B=0x1111_1111, cin=0 → out_sum=0x2345_6789, out_cout=0.
- Random back-to-back: 1000 ops with in_valid and out_ready held high; compare each {out_cout, out_sum} to the golden A+B+cin → zero mismatches, one result every 6 cycles.

Source files
------------

// File: rtl/rca_pkg.sv
// ---------------------------------------------------------------------------
// rca_pkg
// Shared definitions for the chunked sequential ripple-carry adder.
//   CHUNK_W   : width of the single ripple-carry slice (rca_8bit)
//   state_e   : sequencer state encoding
//   cnt_width : slice-counter width, clog2(n) with a floor of 1 bit
// ---------------------------------------------------------------------------
package rca_pkg;

    localparam int CHUNK_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-slice configuration still needs a real register bit for the
    // counter, so the result never drops below 1.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rca_8bit.sv
// ---------------------------------------------------------------------------
// rca_8bit
// Purely combinational 8-bit ripple-carry adder; the slice datapath that the
// sequential front-end reuses once per cycle.
// Ports:
//   a_i, b_i  [7:0]  addends
//   cin_i            carry into bit 0
//   sum_o     [7:0]  a_i + b_i + cin_i, low 8 bits
//   cout_o           carry out of bit 7
// ---------------------------------------------------------------------------
module rca_8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);

    logic carry;

    // Carry is a loop-local running value so the chain stays a true ripple of
    // full adders without a self-referencing carry vector.
    always_comb begin
        carry = cin_i;
        sum_o = '0;
        for (int i = 0; i < 8; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

// File: rtl/rca_chunk_seq_adder.sv
// ---------------------------------------------------------------------------
// rca_chunk_seq_adder
// Adds two WIDTH-bit operands by pushing one CHUNK-bit slice per cycle through
// a single rca_8bit, registering the slice carry between cycles.
//
// State table:
//   IDLE | waiting for operands, in_ready high
//   RUN  | one slice added per cycle, NCHUNK cycles
//   DONE | result held on out_sum/out_cout until out_ready
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid      operand request        in_ready   operands can be taken
//   in_a, in_b    WIDTH-bit operands     in_cin     carry into bit 0
//   out_valid     result available       out_ready  consumer takes result
//   out_sum       A+B+cin low WIDTH bits out_cout   carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
module rca_chunk_seq_adder
    import rca_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = cnt_width(NCHUNK);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_width
            $error("rca_chunk_seq_adder: WIDTH must be a multiple of CHUNK");
        end
        if (CHUNK != CHUNK_W) begin : g_bad_chunk
            $error("rca_chunk_seq_adder: CHUNK must match the 8-bit slice");
        end
    endgenerate

    state_e             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   sum_sh_q;
    logic [WIDTH-1:0]   sum_sh_d;
    logic               carry_q;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   out_sum_q;
    logic               out_cout_q;

    logic [CHUNK-1:0]   chunk_sum;
    logic               chunk_cout;

    rca_8bit u_slice (
        .a_i    (a_sh_q[CHUNK-1:0]),
        .b_i    (b_sh_q[CHUNK-1:0]),
        .cin_i  (carry_q),
        .sum_o  (chunk_sum),
        .cout_o (chunk_cout)
    );

    // Slice sums enter at the top and shift down, so after NCHUNK cycles the
    // first (least significant) slice has reached bit 0.
    generate
        if (NCHUNK == 1) begin : g_sum_single
            assign sum_sh_d = chunk_sum;
        end else begin : g_sum_shift
            assign sum_sh_d = {chunk_sum, sum_sh_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    // rst gates in_ready directly so no operand is acknowledged during reset.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            sum_sh_q   <= '0;
            carry_q    <= 1'b0;
            count_q    <= '0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Operands are sampled only on a real accept, so
                    // unknown values on idle inputs never reach the datapath.
                    if (in_valid && in_ready) begin
                        a_sh_q  <= in_a;
                        b_sh_q  <= in_b;
                        carry_q <= in_cin;
                        count_q <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_sh_q <= sum_sh_d;
                    carry_q  <= chunk_cout;
                    a_sh_q   <= a_sh_q >> CHUNK;
                    b_sh_q   <= b_sh_q >> CHUNK;
                    count_q  <= count_q + 1'b1;
                    if (count_q == LAST_CNT) begin
                        out_sum_q  <= sum_sh_d;
                        out_cout_q <= chunk_cout;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    // No accept on the handoff edge: IDLE is entered first.
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_chunk_seq_adder.sv
module tb_rca_chunk_seq_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;

    logic        v_in_valid;
    logic        v_in_ready;
    logic [7:0]  v_in_a;
    logic [7:0]  v_in_b;
    logic        v_in_cin;
    logic        v_out_valid;
    logic        v_out_ready;
    logic [7:0]  v_out_sum;
    logic        v_out_cout;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rca_chunk_seq_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    // Single-slice configuration: RUN lasts exactly one cycle.
    rca_chunk_seq_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v_in_valid),
        .in_ready  (v_in_ready),
        .in_a      (v_in_a),
        .in_b      (v_in_b),
        .in_cin    (v_in_cin),
        .out_valid (v_out_valid),
        .out_ready (v_out_ready),
        .out_sum   (v_out_sum),
        .out_cout  (v_out_cout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at #1 after an edge. Returns after DONE is reached; if out_ready
    // is high it also steps through the handoff edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          output logic [31:0] s, output logic c,
                          output int lat, output int acc_cyc);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) check("accept_timeout", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_cin   = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s = out_sum;
        c = out_cout;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        logic        c;
        int          lat;
        int          acc;
        int          prev_acc;
        logic [31:0] ra, rb;
        logic        rc;
        logic [32:0] exp33;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        v_in_valid = 1'b0; v_in_a = '0; v_in_b = '0; v_in_cin = 1'b0; v_out_ready = 1'b1;

        // Reset
        @(posedge clk); #1;
        check("rst_in_ready",  {63'd0, in_ready},  64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_sum",   {32'd0, out_sum},   64'd0);
        check("rst_out_cout",  {63'd0, out_cout},  64'd0);
        @(posedge clk); #1;
        check("rst_in_ready2", {63'd0, in_ready},  64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;

        // Carry into slice 1, latency
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, s, c, lat, acc);
        check("c1_sum",     {32'd0, s},  64'h0000_0100);
        check("c1_cout",    {63'd0, c},  64'd0);
        check("c1_latency", lat,         64'd4);
        check("c1_after_valid", {63'd0, out_valid}, 64'd0);
        check("c1_after_sum",   {32'd0, out_sum},   64'h0000_0100);

        // Full ripple cases
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, s, c, lat, acc);
        check("ripple1_sum",  {32'd0, s}, 64'd0);
        check("ripple1_cout", {63'd0, c}, 64'd1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, s, c, lat, acc);
        check("msb_sum",  {32'd0, s}, 64'd0);
        check("msb_cout", {63'd0, c}, 64'd1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, s, c, lat, acc);
        check("ones_sum",  {32'd0, s}, 64'hFFFF_FFFF);
        check("ones_cout", {63'd0, c}, 64'd1);

        // Backpressure
        out_ready = 1'b0;
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, s, c, lat, acc);
        check("bp_sum", {32'd0, s}, 64'h2345_6789);
        in_valid = 1'b1; in_a = 32'd5; in_b = 32'd7; in_cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_stall_valid", {63'd0, out_valid}, 64'd1);
            check("bp_stall_sum",   {32'd0, out_sum},   64'h2345_6789);
            check("bp_stall_ready", {63'd0, in_ready},  64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_handoff_valid", {63'd0, out_valid}, 64'd0);
        check("bp_handoff_ready", {63'd0, in_ready},  64'd1);
        check("bp_handoff_sum",   {32'd0, out_sum},   64'h2345_6789);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_accepted", {63'd0, in_ready}, 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_new_latency", lat, 64'd4);
        check("bp_new_sum",  {32'd0, out_sum},  64'd13);
        check("bp_new_cout", {63'd0, out_cout}, 64'd0);
        @(posedge clk); #1;

        // Reset mid-RUN
        in_valid = 1'b1; in_a = 32'hAAAA_AAAA; in_b = 32'h5555_5555; in_cin = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_in_ready",  {63'd0, in_ready},  64'd1);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_out_sum",   {32'd0, out_sum},   64'd0);
        check("abort_out_cout",  {63'd0, out_cout},  64'd0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, s, c, lat, acc);
        check("abort_next_sum",  {32'd0, s}, 64'h2345_6789);
        check("abort_next_cout", {63'd0, c}, 64'd0);
        check("abort_next_lat",  lat,        64'd4);

        // Single-slice instance
        v_in_valid = 1'b1; v_in_a = 8'hFF; v_in_b = 8'h01; v_in_cin = 1'b1;
        @(posedge clk); #1;
        v_in_valid = 1'b0;
        check("n1_run_valid", {63'd0, v_out_valid}, 64'd0);
        @(posedge clk); #1;
        check("n1_valid", {63'd0, v_out_valid}, 64'd1);
        check("n1_sum",   {56'd0, v_out_sum},   64'h01);
        check("n1_cout",  {63'd0, v_out_cout},  64'd1);
        @(posedge clk); #1;

        // Random back-to-back
        prev_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            exp33 = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            run_op(ra, rb, rc, s, c, lat, acc);
            check("rand_result", {31'd0, c, s}, {31'd0, exp33});
            if (i > 0) check("rand_period", acc - prev_acc, 64'd6);
            prev_acc = acc;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
